// File: rtl/sniffer_pkg.sv
// Shared FSM encoding and default sizing for the multi-pattern stream matcher.
package sniffer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_PAT = 4;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = 64;
endpackage

// File: rtl/window_compare.sv
// Checks one pattern against every byte position of the current beat.
// ext_data byte n sits at [n*8 +: 8]; n=0 is the oldest window byte, the beat occupies the top BYTES bytes.
module window_compare
  import sniffer_pkg::*;
#(
  parameter int BYTES   = DEF_DATA_W / 8,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(DEF_MAX_LEN + 1)
) (
  input  logic [(MAX_LEN+BYTES)*8-1:0] ext_data,
  input  logic [MAX_LEN+BYTES-1:0]     ext_vld,
  input  logic [MAX_LEN*8-1:0]         pattern,
  input  logic [LEN_W-1:0]             len,
  output logic                         match
);
  logic             w_enable;
  logic [BYTES-1:0] w_pos_hit;
  int               w_idx;

  assign w_enable = (len != '0) && (int'(len) <= MAX_LEN);

  // Position j ends at ext byte MAX_LEN+j; pattern byte i lines up len-1-i bytes before that.
  always_comb begin
    w_pos_hit = '0;
    w_idx     = 0;
    for (int j = 0; j < BYTES; j++) begin
      w_pos_hit[j] = w_enable;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (w_enable && (i < int'(len))) begin
          w_idx = MAX_LEN + j - int'(len) + 1 + i;
          if (!ext_vld[w_idx] || (ext_data[w_idx*8 +: 8] != pattern[(MAX_LEN-1-i)*8 +: 8]))
            w_pos_hit[j] = 1'b0;
        end
      end
    end
  end

  assign match = |w_pos_hit;
endmodule

// File: rtl/multi_pattern_matcher.sv
// Streaming multi-pattern matcher: counts packets containing each configured byte pattern.
//   state      | meaning
//   ST_IDLE    | no packet open; non-sop beats ignored; shadow patterns used directly
//   ST_SCAN    | packet open, beats shifted through the window and compared
//   ST_DISCARD | errored packet open; beats dropped until eop, no commit
module multi_pattern_matcher
  import sniffer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_PAT = DEF_NUM_PAT,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           valid,
  input  logic                           sop,
  input  logic                           eop,
  input  logic [$clog2(DATA_W/8)-1:0]    empty,
  input  logic [5:0]                     error,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_PAT)-1:0]     cfg_idx,
  input  logic [MAX_LEN*8-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  output logic [NUM_PAT*CNT_W-1:0]       hits,
  output logic [NUM_PAT-1:0]             pkt_match,
  output logic                           match_valid,
  output logic                           busy
);
  localparam int BYTES = DATA_W / 8;
  localparam int EXT   = MAX_LEN + BYTES;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e               r_state;
  logic [MAX_LEN*8-1:0] r_win_data;
  logic [MAX_LEN-1:0]   r_win_vld;
  logic [MAX_LEN*8-1:0] r_shd_pat [NUM_PAT];
  logic [LEN_W-1:0]     r_shd_len [NUM_PAT];
  logic [MAX_LEN*8-1:0] r_act_pat [NUM_PAT];
  logic [LEN_W-1:0]     r_act_len [NUM_PAT];
  logic [CNT_W-1:0]     r_hits    [NUM_PAT];
  logic [NUM_PAT-1:0]   r_flags;
  logic [NUM_PAT-1:0]   r_pkt_match;
  logic                 r_match_valid;

  state_e               w_state_next;
  logic                 w_beat;
  logic                 w_errored;
  logic                 w_commit;
  logic                 w_use_shadow;
  logic [EXT*8-1:0]     w_ext_data;
  logic [EXT-1:0]       w_ext_vld;
  logic [MAX_LEN*8-1:0] w_win_data_next;
  logic [MAX_LEN-1:0]   w_win_vld_next;
  logic [NUM_PAT-1:0]   w_match;
  logic [NUM_PAT-1:0]   w_flags_next;
  int                   w_nbytes;

  assign w_beat       = valid && (sop || (r_state == ST_SCAN));
  assign w_errored    = (error != 6'd0);
  assign w_commit     = w_beat && eop && !w_errored;
  // A new packet must already see patterns written while the previous one was open.
  assign w_use_shadow = (r_state == ST_IDLE) || (valid && sop);
  assign w_flags_next = (sop ? '0 : r_flags) | w_match;

  always_comb begin
    w_ext_data = '0;
    w_ext_vld  = '0;
    w_ext_data[MAX_LEN*8-1:0] = r_win_data;
    w_ext_vld[MAX_LEN-1:0]    = sop ? '0 : r_win_vld;
    w_nbytes = eop ? (BYTES - int'(empty)) : BYTES;
    for (int j = 0; j < BYTES; j++) begin
      w_ext_data[(MAX_LEN+j)*8 +: 8] = data_in[(BYTES-1-j)*8 +: 8];
      w_ext_vld[MAX_LEN+j]           = (j < w_nbytes);
    end
    w_win_data_next = '0;
    w_win_vld_next  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_win_data_next[i*8 +: 8] = w_ext_data[(i+w_nbytes)*8 +: 8];
      w_win_vld_next[i]         = w_ext_vld[i+w_nbytes];
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_beat) begin
      if (eop)            w_state_next = ST_IDLE;
      else if (w_errored) w_state_next = ST_DISCARD;
      else                w_state_next = ST_SCAN;
    end else if (valid && eop && (r_state == ST_DISCARD)) begin
      w_state_next = ST_IDLE;
    end
  end

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_pat
    logic [MAX_LEN*8-1:0] w_pat;
    logic [LEN_W-1:0]     w_len;
    assign w_pat = w_use_shadow ? r_shd_pat[k] : r_act_pat[k];
    assign w_len = w_use_shadow ? r_shd_len[k] : r_act_len[k];
    window_compare #(.BYTES(BYTES), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
      .ext_data (w_ext_data),
      .ext_vld  (w_ext_vld),
      .pattern  (w_pat),
      .len      (w_len),
      .match    (w_match[k])
    );
    assign hits[k*CNT_W +: CNT_W] = r_hits[k];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_win_data    <= '0;
      r_win_vld     <= '0;
      r_flags       <= '0;
      r_pkt_match   <= '0;
      r_match_valid <= 1'b0;
      for (int k = 0; k < NUM_PAT; k++) begin
        r_shd_len[k] <= '0;
        r_act_len[k] <= '0;
        r_hits[k]    <= '0;
      end
    end else begin
      r_state       <= w_state_next;
      r_match_valid <= w_commit;
      if (w_beat) begin
        r_win_data <= w_win_data_next;
        r_win_vld  <= w_win_vld_next;
        r_flags    <= w_flags_next;
      end
      if (w_commit) r_pkt_match <= w_flags_next;
      for (int k = 0; k < NUM_PAT; k++) begin
        if (w_commit && w_flags_next[k] && (r_hits[k] != '1))
          r_hits[k] <= r_hits[k] + CNT_W'(1);
        if (w_use_shadow) begin
          r_act_pat[k] <= r_shd_pat[k];
          r_act_len[k] <= r_shd_len[k];
        end
        if (cfg_we && (int'(cfg_idx) == k)) begin
          r_shd_pat[k] <= cfg_pattern;
          r_shd_len[k] <= cfg_len;
        end
      end
    end
  end

  assign pkt_match   = r_pkt_match;
  assign match_valid = r_match_valid;
  assign busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_multi_pattern_matcher.sv
// Directed bench for multi_pattern_matcher: default instance plus a 4-bit-counter instance for saturation.
module tb_multi_pattern_matcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;
  logic [31:0]  data_in;
  logic         valid, sop, eop;
  logic [1:0]   empty;
  logic [5:0]   error;
  logic         cfg_we;
  logic [1:0]   cfg_idx;
  logic [127:0] cfg_pattern;
  logic [4:0]   cfg_len;
  logic [255:0] hits;
  logic [3:0]   pkt_match;
  logic         match_valid, busy;
  logic [15:0]  s_hits;
  logic [3:0]   s_pkt_match;
  logic         s_match_valid, s_busy;

  multi_pattern_matcher u_dut (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .valid(valid), .sop(sop), .eop(eop),
    .empty(empty), .error(error), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .hits(hits), .pkt_match(pkt_match),
    .match_valid(match_valid), .busy(busy)
  );

  multi_pattern_matcher #(.CNT_W(4)) u_sat (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .valid(valid), .sop(sop), .eop(eop),
    .empty(empty), .error(error), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .hits(s_hits), .pkt_match(s_pkt_match),
    .match_valid(s_match_valid), .busy(s_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic         busy_mid;
  logic [1:0]   pend_idx = 2'd0;
  logic [127:0] pend_pat = '0;
  logic [4:0]   pend_len = 5'd0;
  logic [7:0]   pkt_q [$];

  localparam logic [127:0] MAC_PAT = {8'h64, 8'h12, 8'h25, 8'heb, 8'h10, 8'h80, 80'h0};

  function automatic logic [127:0] pack_pat(input string s);
    logic [127:0] p = '0;
    for (int i = 0; i < s.len() && i < 16; i++) p[127-8*i -: 8] = s[i];
    return p;
  endfunction

  task automatic pkt_add(input string s);
    for (int i = 0; i < s.len(); i++) pkt_q.push_back(s[i]);
  endtask

  task automatic pkt_crlf();
    pkt_q.push_back(8'h0d);
    pkt_q.push_back(8'h0a);
  endtask

  // 6-byte MAC + "GET /ab HTTP/1.1\r\nHost: <host>\r\n\r\n" = 47 bytes, so eop carries empty=1
  task automatic build_http(input string host);
    pkt_q.delete();
    pkt_q.push_back(8'h64); pkt_q.push_back(8'h12); pkt_q.push_back(8'h25);
    pkt_q.push_back(8'heb); pkt_q.push_back(8'h10); pkt_q.push_back(8'h80);
    pkt_add("GET /ab HTTP/1.1"); pkt_crlf();
    pkt_add("Host: "); pkt_add(host); pkt_crlf(); pkt_crlf();
  endtask

  task automatic idle_inputs();
    valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = 2'd0; error = 6'd0; cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [127:0] pat, input int len);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_pattern = pat; cfg_len = 5'(len);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // nvalid<0 means all queued bytes are real; returns at the negedge after the last beat's edge
  task automatic send_pkt(input int nvalid, input int err_beat, input bit close, input int cfg_beat);
    int nbeats;
    if (nvalid < 0) nvalid = pkt_q.size();
    while (pkt_q.size() % 4 != 0) pkt_q.push_back(8'h00);
    nbeats = pkt_q.size() / 4;
    busy_mid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == 1) busy_mid = busy;
      data_in = {pkt_q[4*b], pkt_q[4*b+1], pkt_q[4*b+2], pkt_q[4*b+3]};
      valid   = 1'b1;
      sop     = (b == 0);
      eop     = close && (b == nbeats - 1);
      empty   = eop ? 2'(pkt_q.size() - nvalid) : 2'd0;
      error   = (b == err_beat) ? 6'h3F : 6'h00;
      cfg_we  = (b == cfg_beat);
      cfg_idx = pend_idx; cfg_pattern = pend_pat; cfg_len = pend_len;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    data_in = '0; cfg_idx = '0; cfg_pattern = '0; cfg_len = '0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (hits !== '0) begin n_err++; $display("FAIL reset_hits: got %0h expected 0", hits); end
    n_vec++; if (pkt_match !== 4'b0) begin n_err++; $display("FAIL reset_pkt_match: got %b expected 0000", pkt_match); end
    n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL reset_match_valid: got %b expected 0", match_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (s_hits !== 16'h0) begin n_err++; $display("FAIL reset_sat_hits: got %0h expected 0", s_hits); end
    n_rst = 1'b1;
  endtask

  task automatic test_http_host();
    cfg_write(0, pack_pat("www.wired.com"), 13);
    build_http("www.wired.com");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL http_mv: got %b expected 1", match_valid); end
    n_vec++; if (pkt_match !== 4'b0001) begin n_err++; $display("FAIL http_pkt_match: got %b expected 0001", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd1) begin n_err++; $display("FAIL http_hits0: got %0d expected 1", hits[0 +: 64]); end
    n_vec++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL http_busy_mid: got %b expected 1", busy_mid); end
    @(negedge clk);
    n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL http_mv_pulse: got %b expected 0", match_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL http_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_multi_pattern();
    cfg_write(1, MAC_PAT, 6);
    cfg_write(2, pack_pat("www.purdue.edu"), 14);
    build_http("www.wired.com");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b0011) begin n_err++; $display("FAIL multi_pkt_match: got %b expected 0011", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd2) begin n_err++; $display("FAIL multi_hits0: got %0d expected 2", hits[0 +: 64]); end
    n_vec++; if (hits[64 +: 64] !== 64'd1) begin n_err++; $display("FAIL multi_hits1: got %0d expected 1", hits[64 +: 64]); end
    n_vec++; if (hits[128 +: 64] !== 64'd0) begin n_err++; $display("FAIL multi_hits2: got %0d expected 0", hits[128 +: 64]); end
    // same pattern twice in one packet counts once
    pkt_q.delete();
    pkt_add("GET /ab HTTP/1.1"); pkt_crlf();
    pkt_add("Host: www.wired.com"); pkt_crlf();
    pkt_add("Referer: www.wired.com"); pkt_crlf();
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b0001) begin n_err++; $display("FAIL double_pkt_match: got %b expected 0001", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd3) begin n_err++; $display("FAIL double_hits0: got %0d expected 3", hits[0 +: 64]); end
    n_vec++; if (hits[64 +: 64] !== 64'd1) begin n_err++; $display("FAIL double_hits1: got %0d expected 1", hits[64 +: 64]); end
  endtask

  task automatic test_error();
    build_http("www.wired.com");
    send_pkt(-1, 2, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL err_mv: got %b expected 0", match_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_busy: got %b expected 0", busy); end
    n_vec++; if (hits[0 +: 64] !== 64'd3) begin n_err++; $display("FAIL err_hits0: got %0d expected 3", hits[0 +: 64]); end
    n_vec++; if (hits[64 +: 64] !== 64'd1) begin n_err++; $display("FAIL err_hits1: got %0d expected 1", hits[64 +: 64]); end
    n_vec++; if (pkt_match !== 4'b0001) begin n_err++; $display("FAIL err_pkt_match: got %b expected 0001", pkt_match); end
  endtask

  task automatic test_cfg_and_abort();
    // slot 0 rewritten to purdue on beat 1; wired arrives later and must still match
    pend_idx = 2'd0; pend_pat = pack_pat("www.purdue.edu"); pend_len = 5'd14;
    pkt_q.delete();
    pkt_add("GET /ab HTTP/1.1"); pkt_crlf();
    pkt_add("Host: www.wired.com"); pkt_crlf();
    send_pkt(-1, -1, 1'b1, 1);
    n_vec++; if (pkt_match !== 4'b0001) begin n_err++; $display("FAIL midcfg_pkt_match: got %b expected 0001", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd4) begin n_err++; $display("FAIL midcfg_hits0: got %0d expected 4", hits[0 +: 64]); end
    pkt_q.delete();
    pkt_add("Host: www.purdue.edu");
    send_pkt(-1, -1, 1'b0, -1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_open_busy: got %b expected 1", busy); end
    pkt_q.delete();
    pkt_add("Host: www.wired.com"); pkt_crlf();
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL abort_mv: got %b expected 1", match_valid); end
    n_vec++; if (pkt_match !== 4'b0000) begin n_err++; $display("FAIL abort_pkt_match: got %b expected 0000", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd4) begin n_err++; $display("FAIL abort_hits0: got %0d expected 4", hits[0 +: 64]); end
    n_vec++; if (hits[128 +: 64] !== 64'd0) begin n_err++; $display("FAIL abort_hits2: got %0d expected 0", hits[128 +: 64]); end
    pkt_q.delete();
    pkt_add("Host: www.purdue.edu"); pkt_crlf();
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b0101) begin n_err++; $display("FAIL newpat_pkt_match: got %b expected 0101", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd5) begin n_err++; $display("FAIL newpat_hits0: got %0d expected 5", hits[0 +: 64]); end
    n_vec++; if (hits[128 +: 64] !== 64'd1) begin n_err++; $display("FAIL newpat_hits2: got %0d expected 1", hits[128 +: 64]); end
  endtask

  task automatic test_empty_tail();
    pkt_q.delete();
    pkt_add("abwww.purdue.edu");
    send_pkt(15, -1, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL tail_mv: got %b expected 1", match_valid); end
    n_vec++; if (pkt_match !== 4'b0000) begin n_err++; $display("FAIL tail_pkt_match: got %b expected 0000", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd5) begin n_err++; $display("FAIL tail_hits0: got %0d expected 5", hits[0 +: 64]); end
    pkt_q.delete();
    pkt_add("abcwww.purdue.edu");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b0101) begin n_err++; $display("FAIL lastbyte_pkt_match: got %b expected 0101", pkt_match); end
    n_vec++; if (hits[0 +: 64] !== 64'd6) begin n_err++; $display("FAIL lastbyte_hits0: got %0d expected 6", hits[0 +: 64]); end
    n_vec++; if (hits[128 +: 64] !== 64'd2) begin n_err++; $display("FAIL lastbyte_hits2: got %0d expected 2", hits[128 +: 64]); end
  endtask

  task automatic test_single_beat_and_len();
    cfg_write(3, pack_pat("ab"), 2);
    pkt_q.delete(); pkt_add("xabz");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL single_mv: got %b expected 1", match_valid); end
    n_vec++; if (pkt_match !== 4'b1000) begin n_err++; $display("FAIL single_pkt_match: got %b expected 1000", pkt_match); end
    n_vec++; if (hits[192 +: 64] !== 64'd1) begin n_err++; $display("FAIL single_hits3: got %0d expected 1", hits[192 +: 64]); end
    // valid beat without sop while idle is dropped
    @(negedge clk);
    data_in = {8'h78, 8'h61, 8'h62, 8'h7a}; valid = 1'b1; sop = 1'b0; eop = 1'b1;
    @(negedge clk);
    idle_inputs();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nosop_busy: got %b expected 0", busy); end
    @(negedge clk);
    n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL nosop_mv: got %b expected 0", match_valid); end
    cfg_write(3, pack_pat("ab"), 17);
    pkt_q.delete(); pkt_add("xabz");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b0000) begin n_err++; $display("FAIL len17_pkt_match: got %b expected 0000", pkt_match); end
    n_vec++; if (hits[192 +: 64] !== 64'd1) begin n_err++; $display("FAIL len17_hits3: got %0d expected 1", hits[192 +: 64]); end
    cfg_write(3, pack_pat("0123456789ABCDEF"), 16);
    pkt_q.delete(); pkt_add("0123456789ABCDEF");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (pkt_match !== 4'b1000) begin n_err++; $display("FAIL len16_pkt_match: got %b expected 1000", pkt_match); end
    n_vec++; if (hits[192 +: 64] !== 64'd2) begin n_err++; $display("FAIL len16_hits3: got %0d expected 2", hits[192 +: 64]); end
  endtask

  task automatic test_reset_mid_packet();
    pkt_q.delete(); pkt_add("Host: www.purdue.edu");
    send_pkt(-1, -1, 1'b0, -1);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_mv: got %b expected 0", match_valid); end
    n_vec++; if (hits !== '0) begin n_err++; $display("FAIL rstmid_hits: got %0h expected 0", hits); end
    n_vec++; if (pkt_match !== 4'b0000) begin n_err++; $display("FAIL rstmid_pkt_match: got %b expected 0000", pkt_match); end
    // all patterns are disabled after reset
    pkt_q.delete(); pkt_add("Host: www.purdue.edu www.wired.com xabz");
    send_pkt(-1, -1, 1'b1, -1);
    n_vec++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_next_mv: got %b expected 1", match_valid); end
    n_vec++; if (pkt_match !== 4'b0000) begin n_err++; $display("FAIL rstmid_next_pkt_match: got %b expected 0000", pkt_match); end
  endtask

  task automatic test_saturation();
    cfg_write(0, pack_pat("ab"), 2);
    for (int n = 1; n <= 16; n++) begin
      pkt_q.delete(); pkt_add("abcd");
      send_pkt(-1, -1, 1'b1, -1);
      if (n == 14) begin
        n_vec++; if (s_hits[3:0] !== 4'hE) begin n_err++; $display("FAIL sat_14: got %0h expected e", s_hits[3:0]); end
      end
      if (n == 15) begin
        n_vec++; if (s_hits[3:0] !== 4'hF) begin n_err++; $display("FAIL sat_15: got %0h expected f", s_hits[3:0]); end
      end
    end
    n_vec++; if (s_hits[3:0] !== 4'hF) begin n_err++; $display("FAIL sat_16: got %0h expected f", s_hits[3:0]); end
    n_vec++; if (s_hits[15:4] !== 12'h0) begin n_err++; $display("FAIL sat_others: got %0h expected 0", s_hits[15:4]); end
    n_vec++; if (hits[0 +: 64] !== 64'd16) begin n_err++; $display("FAIL wide_16: got %0d expected 16", hits[0 +: 64]); end
  endtask

  initial begin
    test_reset();
    test_http_host();
    test_multi_pattern();
    test_error();
    test_cfg_and_abort();
    test_empty_tail();
    test_single_beat_and_len();
    test_reset_mid_packet();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_pattern_matcher.md
MULTI_PATTERN_MATCHER -- requirements
Module: multi_pattern_matcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and n_rst; all state changes only on rising clk; n_rst=0 sampled at a rising edge resets.
REQ-002 Parameters (name, default, meaning):
- DATA_W, 32: stream word width; multiple of 8; BYTES=DATA_W/8.
- NUM_PAT, 4: number of independent patterns.
- MAX_LEN, 16: maximum pattern length in bytes.
- CNT_W, 64: hit counter width.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- n_rst, in, 1, sync active-low reset.
- data_in, in, DATA_W, stream word; first byte in data_in[DATA_W-1 -: 8].
- valid, in, 1, beat qualifier.
- sop, in, 1, first beat of packet.
- eop, in, 1, last beat of packet.
- empty, in, $clog2(BYTES), unused low-order bytes on eop beat.
- error, in, 6, nonzero marks beat errored.
- cfg_we, in, 1, pattern write strobe.
- cfg_idx, in, $clog2(NUM_PAT), pattern slot.
- cfg_pattern, in, MAX_LEN*8, pattern bytes, byte 0 in MSBs.
- cfg_len, in, $clog2(MAX_LEN+1), pattern length.
- hits, out, NUM_PAT*CNT_W, per-pattern packet hit counters, slot k at [k*CNT_W +: CNT_W].
- pkt_match, out, NUM_PAT, per-pattern match flags of last committed packet.
- match_valid, out, 1, one-cycle commit pulse.
- busy, out, 1, high while a packet is open.

Function
REQ-004 Beats SHALL be consumed only when valid=1; no backpressure.
REQ-005 FSM states SHALL be IDLE, SCAN, DISCARD; IDLE->SCAN on valid&sop; SCAN->IDLE on valid&eop (commit); SCAN->DISCARD on valid beat with error!=0 and eop=0; DISCARD->IDLE on valid&eop (no commit).
REQ-006 A valid&sop&eop beat in IDLE SHALL be processed as a one-beat packet and commit that cycle unless errored.
REQ-007 Beats with valid=1, sop=0 in IDLE SHALL be ignored.
REQ-008 valid&sop in SCAN or DISCARD SHALL abort the open packet without commit and start a new packet with that beat.
REQ-009 The block SHALL hold a MAX_LEN-byte sliding window with per-byte valid bits, cleared at every sop, and SHALL shift in all BYTES bytes of each accepted beat in order, except on eop beats only the first BYTES-empty bytes.
REQ-010 Pattern k SHALL match at each byte position where the newest cfg_len[k] window bytes are all valid and equal pattern bytes 0..len-1 in order; all BYTES positions of a beat SHALL be checked in the same cycle.
REQ-011 A per-packet sticky flag per pattern SHALL record any match; the flag is cleared at sop.
REQ-012 On commit, each set flag SHALL increment its counter by 1 regardless of match count in the packet; pkt_match SHALL take the flags; match_valid SHALL pulse high for the cycle after the eop beat; hits SHALL show new values in that same cycle.
REQ-013 Counters SHALL saturate at all-ones.
REQ-014 Patterns with cfg_len=0 or cfg_len>MAX_LEN SHALL be disabled (never match).
REQ-015 cfg_we SHALL write a shadow slot any cycle; shadow slots SHALL copy to active slots at each accepted sop, or immediately when busy=0. Mid-packet writes SHALL not affect the open packet.
REQ-016 busy SHALL be 1 in SCAN and DISCARD, 0 in IDLE.

Reset
REQ-017 Reset SHALL force IDLE and zero hits, pkt_match, match_valid, busy, window, flags, and shadow and active lengths (all patterns disabled).
REQ-018 Reset mid-packet SHALL discard that packet with no commit.

Structure
REQ-019 Package sniffer_pkg SHALL hold the state enum and the default parameter constants.
REQ-020 One sub-module window_compare SHALL be instantiated per pattern via generate and SHALL do the byte-position comparison for one pattern.

Verification
REQ-021 Reset: n_rst low 2 cycles -> all outputs 0, busy=0.
REQ-022 Pattern 0 = "www.wired.com" (len 13); stream an HTTP GET whose Host field holds it, split across words, empty=1 on eop -> match_valid 1 cycle after eop, pkt_match=4'b0001, hits[0]=1.
REQ-023 Same packet, pattern 1 = 6-byte MAC 64:12:25:eb:10:80 at bytes 0-5, pattern 2 = "www.purdue.edu" -> hits[1]=1, hits[2]=0; pattern 0 at two places in one packet -> hits[0] increments by 1 only.
REQ-024 Error: error=6'h3F on a mid-packet beat, then eop -> no match_valid, counters unchanged, busy=0 after eop.
REQ-025 sop without prior eop, and cfg_we to slot 0 mid-packet -> first packet not committed; the old pattern governs the open packet and the new pattern the next; a pattern ending in the empty (ignored) bytes of eop does not match.
REQ-026 Saturation: counter at max (CNT_W=4) -> matching packet leaves hits[0]=4'hF.
